addsub_arbiter: RTL and testbench

//  Shared add/subtract server for the arithmetic units (cubic root, multiplier-side users).

---
 rtl/addsub_pkg.sv | 16 +
 rtl/addsub_arbiter_if.sv | 34 +++
 rtl/addsub_alu.sv | 20 ++
 rtl/addsub_arbiter.sv | 128 ++++++++++++
 tb/tb_addsub_arbiter.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/addsub_pkg.sv
// addsub_pkg: shared definitions for the add/subtract arbiter slice.
//   MODE_SUB / MODE_ADD : client op encoding (1 = add, 0 = sub a-b)
//   state_t             : arbiter FSM state encoding
package addsub_pkg;

    localparam logic MODE_SUB = 1'b0;
    localparam logic MODE_ADD = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2,
        COOL = 2'd3
    } state_t;

endpackage

// File: rtl/addsub_arbiter_if.sv
// addsub_arbiter_if: two-client request/ready bus of the add/subtract server.
//   c0_/c1_ req_i, mode_i, a_bi, b_bi : client requests and operands
//   c0_/c1_ ready_o                   : one-cycle result-valid pulses
//   res_bo                            : shared result bus
//   busy_o                            : server not idle
// Modports: slave = arbiter side, master = client/stimulus side.
interface addsub_arbiter_if #(parameter int WIDTH = 8);

    logic             c0_req_i;
    logic             c0_mode_i;
    logic [WIDTH-1:0] c0_a_bi;
    logic [WIDTH-1:0] c0_b_bi;
    logic             c0_ready_o;
    logic             c1_req_i;
    logic             c1_mode_i;
    logic [WIDTH-1:0] c1_a_bi;
    logic [WIDTH-1:0] c1_b_bi;
    logic             c1_ready_o;
    logic [WIDTH-1:0] res_bo;
    logic             busy_o;

    modport slave (
        input  c0_req_i, c0_mode_i, c0_a_bi, c0_b_bi,
        input  c1_req_i, c1_mode_i, c1_a_bi, c1_b_bi,
        output c0_ready_o, c1_ready_o, res_bo, busy_o
    );

    modport master (
        output c0_req_i, c0_mode_i, c0_a_bi, c0_b_bi,
        output c1_req_i, c1_mode_i, c1_a_bi, c1_b_bi,
        input  c0_ready_o, c1_ready_o, res_bo, busy_o
    );

endinterface

// File: rtl/addsub_alu.sv
// addsub_alu: combinational WIDTH-bit adder/subtractor, result modulo 2^WIDTH.
//   mode : MODE_ADD -> a+b, MODE_SUB -> a-b (wraps on underflow)
//   a, b : operands
//   res  : result
module addsub_alu
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res
);

    always_comb begin
        res = (mode == MODE_ADD) ? (a + b) : (a - b);
    end

endmodule

// File: rtl/addsub_arbiter.sv
// addsub_arbiter: shared add/subtract server for two clients.
// Serialises level requests, latches the granted client's operands, runs one
// op through addsub_alu and pulses that client's ready for one cycle.
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-low reset
//   bus   : addsub_arbiter_if.slave (requests in, ready/res/busy out)
// Build option: ADDSUB_ARB_RR_EN selects round-robin tie-breaking
// (default: fixed priority, client 0 wins ties).
//
// state | meaning
// IDLE  | waiting; arbitrates between pending requests
// EXEC  | counting down LATENCY cycles, result registered at cnt==0
// RESP  | ready pulse to the granted client
// COOL  | one dead cycle so a client still holding req is not re-served
module addsub_arbiter
    import addsub_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    addsub_arbiter_if.slave  bus
);

    localparam int              CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t           state;
    logic             grant;
    logic             mode_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] res_q;
    logic             rdy0_q;
    logic             rdy1_q;
    logic             busy_q;
    logic [WIDTH-1:0] alu_res;
    logic             pick;

`ifdef ADDSUB_ARB_RR_EN
    logic last_grant;

    // Tie goes to whoever was not served last; otherwise the sole requester.
    always_comb begin
        pick = bus.c1_req_i;
        if (bus.c0_req_i && bus.c1_req_i) begin
            pick = ~last_grant;
        end
    end
`else
    // Client 1 only wins when client 0 is not asking.
    always_comb begin
        pick = ~bus.c0_req_i;
    end
`endif

    addsub_alu #(.WIDTH(WIDTH)) u_alu (
        .mode (mode_q),
        .a    (a_q),
        .b    (b_q),
        .res  (alu_res)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state  <= IDLE;
            grant  <= 1'b0;
            mode_q <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            cnt    <= '0;
            res_q  <= '0;
            rdy0_q <= 1'b0;
            rdy1_q <= 1'b0;
            busy_q <= 1'b0;
`ifdef ADDSUB_ARB_RR_EN
            last_grant <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.c0_req_i || bus.c1_req_i) begin
                        grant  <= pick;
                        mode_q <= pick ? bus.c1_mode_i : bus.c0_mode_i;
                        a_q    <= pick ? bus.c1_a_bi   : bus.c0_a_bi;
                        b_q    <= pick ? bus.c1_b_bi   : bus.c0_b_bi;
                        cnt    <= CNT_LOAD;
                        busy_q <= 1'b1;
                        state  <= EXEC;
`ifdef ADDSUB_ARB_RR_EN
                        last_grant <= pick;
`endif
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        res_q  <= alu_res;
                        rdy0_q <= ~grant;
                        rdy1_q <= grant;
                        state  <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    rdy0_q <= 1'b0;
                    rdy1_q <= 1'b0;
                    state  <= COOL;
                end
                COOL: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.c0_ready_o = rdy0_q;
    assign bus.c1_ready_o = rdy1_q;
    assign bus.res_bo     = res_q;
    assign bus.busy_o     = busy_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// tb_addsub_arbiter: directed self-checking bench for addsub_arbiter
// (WIDTH=8, LATENCY=1). Tie-break expectations follow ADDSUB_ARB_RR_EN.
module tb_addsub_arbiter;
    import addsub_pkg::*;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   last_g  = 1'b1;   // client served most recently (reset value 1)

    addsub_arbiter_if #(.WIDTH(8)) bus ();

    addsub_arbiter #(.WIDTH(8), .LATENCY(1)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input bit c, input bit req, input bit mode,
                         input logic [7:0] a, input logic [7:0] b);
        if (!c) begin
            bus.c0_req_i = req; bus.c0_mode_i = mode; bus.c0_a_bi = a; bus.c0_b_bi = b;
        end else begin
            bus.c1_req_i = req; bus.c1_mode_i = mode; bus.c1_a_bi = a; bus.c1_b_bi = b;
        end
    endtask

    task automatic set_req(input bit c, input bit v);
        if (!c) bus.c0_req_i = v;
        else    bus.c1_req_i = v;
    endtask

    function automatic logic [1:0] rdy_vec(input bit c);
        return c ? 2'b10 : 2'b01;
    endfunction

    // Single op from an idle server. Operands are scrambled right after the
    // grant edge; drop_early releases req mid-op.
    task automatic do_op(input string tag, input bit c, input bit mode,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp, input bit drop_early);
        drive(c, 1'b1, mode, a, b);
        step();                                        // grant
        chk({tag, " busy_exec"}, 32'(bus.busy_o), 32'd1);
        chk({tag, " rdy_exec"}, 32'({bus.c1_ready_o, bus.c0_ready_o}), 32'd0);
        drive(c, !drop_early, !mode, ~a, ~b);
        step();                                        // ready pulse
        chk({tag, " rdy"}, 32'({bus.c1_ready_o, bus.c0_ready_o}), 32'(rdy_vec(c)));
        chk({tag, " res"}, 32'(bus.res_bo), 32'(exp));
        step();                                        // cool
        chk({tag, " rdy_off"}, 32'({bus.c1_ready_o, bus.c0_ready_o}), 32'd0);
        chk({tag, " res_hold"}, 32'(bus.res_bo), 32'(exp));
        set_req(c, 1'b0);
        step();                                        // idle again, no re-serve
        chk({tag, " busy_idle"}, 32'(bus.busy_o), 32'd0);
        step();
        chk({tag, " no_2nd"}, 32'({bus.busy_o, bus.c1_ready_o, bus.c0_ready_o}), 32'd0);
        last_g = c;
    endtask

    // Both clients request together: c0 adds 1+2, c1 subtracts 9-4.
    task automatic tie(input string tag);
        bit w;
`ifdef ADDSUB_ARB_RR_EN
        w = ~last_g;
`else
        w = 1'b0;
`endif
        drive(1'b0, 1'b1, MODE_ADD, 8'h01, 8'h02);
        drive(1'b1, 1'b1, MODE_SUB, 8'h09, 8'h04);
        step();                                        // grant winner
        step();
        chk({tag, " win_rdy"}, 32'({bus.c1_ready_o, bus.c0_ready_o}), 32'(rdy_vec(w)));
        chk({tag, " win_res"}, 32'(bus.res_bo), w ? 32'h05 : 32'h03);
        step();
        chk({tag, " win_off"}, 32'({bus.c1_ready_o, bus.c0_ready_o}), 32'd0);
        set_req(w, 1'b0);
        step();                                        // idle, loser still requesting
        chk({tag, " gap_idle"}, 32'(bus.busy_o), 32'd0);
        step();                                        // grant loser
        chk({tag, " lose_busy"}, 32'(bus.busy_o), 32'd1);
        step();                                        // 4 cycles after winner's ready
        chk({tag, " lose_rdy"}, 32'({bus.c1_ready_o, bus.c0_ready_o}), 32'(rdy_vec(!w)));
        chk({tag, " lose_res"}, 32'(bus.res_bo), w ? 32'h03 : 32'h05);
        step();
        set_req(!w, 1'b0);
        step();
        chk({tag, " end_idle"}, 32'(bus.busy_o), 32'd0);
        last_g = !w;
    endtask

    initial begin
        drive(1'b0, 1'b0, MODE_SUB, 8'h00, 8'h00);
        drive(1'b1, 1'b0, MODE_SUB, 8'h00, 8'h00);
        #12;
        chk("reset ready", 32'({bus.c1_ready_o, bus.c0_ready_o}), 32'd0);
        chk("reset res", 32'(bus.res_bo), 32'd0);
        chk("reset busy", 32'(bus.busy_o), 32'd0);
        rst_i = 1'b1;
        step();

        do_op("c0_sub", 1'b0, MODE_SUB, 8'h40, 8'h08, 8'h38, 1'b0);
        do_op("c1_add", 1'b1, MODE_ADD, 8'h15, 8'h0A, 8'h1F, 1'b0);
        step();
        step();
        chk("c1_add res_long_hold", 32'(bus.res_bo), 32'h1F);
        do_op("c0_wrap_sub", 1'b0, MODE_SUB, 8'h03, 8'h05, 8'hFE, 1'b0);
        do_op("c0_wrap_add", 1'b0, MODE_ADD, 8'hF0, 8'h20, 8'h10, 1'b0);
        tie("tie_a");
        tie("tie_b");
        do_op("c1_drop", 1'b1, MODE_ADD, 8'h7F, 8'h01, 8'h80, 1'b1);

        // Reset while executing: op abandoned.
        drive(1'b0, 1'b1, MODE_SUB, 8'h50, 8'h10);
        step();                                        // grant
        #2;
        rst_i = 1'b0;
        #1;
        chk("rst_exec ready", 32'({bus.c1_ready_o, bus.c0_ready_o}), 32'd0);
        chk("rst_exec busy", 32'(bus.busy_o), 32'd0);
        chk("rst_exec res", 32'(bus.res_bo), 32'd0);
        set_req(1'b0, 1'b0);
        step();
        #3;
        rst_i = 1'b1;
        last_g = 1'b1;
        step();
        step();
        chk("rst_exec no_pulse", 32'({bus.busy_o, bus.c1_ready_o, bus.c0_ready_o}), 32'd0);
        do_op("post_rst", 1'b0, MODE_ADD, 8'h11, 8'h22, 8'h33, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
